// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// BASE_ADDR defaults to the reset PC, so word 0 is the first fetched word.
package dmem_pkg;

  localparam int XLEN   = 64;
  localparam int MASK_W = 8;

  localparam logic [XLEN-1:0] PC_RESET_ADDR     = 64'h8000_0000;
  localparam logic [XLEN-1:0] DEFAULT_BASE_ADDR = PC_RESET_ADDR;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Apply a byte-lane write mask to an existing word.
  function automatic logic [XLEN-1:0] merge_lanes(input logic [XLEN-1:0] old_word,
                                                  input logic [XLEN-1:0] new_word,
                                                  input logic [MASK_W-1:0] mask);
    logic [XLEN-1:0] res;
    res = old_word;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables.
// The read port returns the word as it was before a same-edge write.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              wen,
  input  logic [AW-1:0]     addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [MASK_W-1:0] wmask,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (wen) begin
        for (int i = 0; i < MASK_W; i++) begin
          if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store target: one request in flight, fixed programmable response latency.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | ready for a request; req_ready high when not in reset
//   WAIT  | request accepted, down-counting until response is due
//   RESP  | response presented, held until resp_ready handshake
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int              LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err
);

  localparam int              AW      = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] DEPTH_X = XLEN'(DEPTH_WORDS);
  localparam logic [3:0]      LAT_M1  = 4'(LATENCY - 1);

  dmem_state_t     state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            err_q;
  logic            rd_ok_q;
  logic [XLEN-1:0] offset;
  logic            addr_err;
  logic            accept;
  logic [XLEN-1:0] arr_rdata;

  // Unsigned subtraction: anything below BASE_ADDR wraps to a huge offset,
  // but the explicit compare keeps that case obvious.
  assign offset   = req_addr - BASE_ADDR;
  assign addr_err = (req_addr < BASE_ADDR) || ((offset >> 3) >= DEPTH_X);

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Errored requests never touch the array, so an out-of-range store
  // cannot alias onto a low word through index truncation.
  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .en    (accept && !addr_err),
    .wen   (req_wen),
    .addr  (offset[AW+2:3]),
    .wdata (req_wdata),
    .wmask (req_wmask),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_M1;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        err_q   <= addr_err;
        rd_ok_q <= !addr_err && !req_wen;
      end
    end
  end

  // The array read register holds its word until the next accepted request,
  // which cannot happen before this response completes.
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && rd_ok_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vectors, corner sequences,
// randomized traffic against a byte-lane memory model, and a LATENCY=1 build.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int              DEPTH = 1024;
  localparam logic [63:0]     BASE  = 64'h8000_0000;
  localparam int              LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;

  logic        r1_req_valid, r1_req_ready, r1_req_wen;
  logic [63:0] r1_req_addr, r1_req_wdata;
  logic [7:0]  r1_req_wmask;
  logic        r1_resp_valid, r1_resp_ready, r1_resp_err;
  logic [63:0] r1_resp_rdata;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem_m [longint unsigned];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(r1_req_valid), .req_ready(r1_req_ready), .req_wen(r1_req_wen),
    .req_addr(r1_req_addr), .req_wdata(r1_req_wdata), .req_wmask(r1_req_wmask),
    .resp_valid(r1_resp_valid), .resp_ready(r1_resp_ready),
    .resp_rdata(r1_resp_rdata), .resp_err(r1_resp_err)
  );

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic in_range(input logic [63:0] a);
    return (a >= BASE) && (((a - BASE) / 8) < 64'(DEPTH));
  endfunction

  function automatic longint unsigned word_idx(input logic [63:0] a);
    return longint'((a - BASE) / 8);
  endfunction

  task automatic model_apply(input logic wen, input logic [63:0] a,
                             input logic [63:0] d, input logic [7:0] m);
    logic [63:0] w;
    if (wen && in_range(a)) begin
      w = mem_m.exists(word_idx(a)) ? mem_m[word_idx(a)] : 64'h0;
      for (int i = 0; i < 8; i++)
        if (m[i]) w[8*i +: 8] = d[8*i +: 8];
      mem_m[word_idx(a)] = w;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the LATENCY=2 instance, with optional backpressure.
  task automatic txn(input logic wen, input logic [63:0] a, input logic [63:0] d,
                     input logic [7:0] m, input int hold,
                     input logic exp_err, input logic [63:0] exp_rd);
    int k;
    chk("req_ready_idle", {63'h0, req_ready}, 64'h1);
    req_wen = wen; req_addr = a; req_wdata = d; req_wmask = m; req_valid = 1'b1;
    next_cycle();
    req_valid = 1'b0;
    chk("req_ready_busy", {63'h0, req_ready}, 64'h0);
    k = 1;
    while (!resp_valid && k < 20) begin
      next_cycle();
      k++;
    end
    chk("latency", 64'(k), 64'(LAT));
    chk("resp_valid", {63'h0, resp_valid}, 64'h1);
    chk("resp_err", {63'h0, resp_err}, {63'h0, exp_err});
    chk("resp_rdata", resp_rdata, exp_rd);
    for (int h = 0; h < hold; h++) begin
      next_cycle();
      chk("hold_valid", {63'h0, resp_valid}, 64'h1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_err", {63'h0, resp_err}, {63'h0, exp_err});
      chk("hold_req_ready", {63'h0, req_ready}, 64'h0);
    end
    resp_ready = 1'b1;
    next_cycle();
    resp_ready = 1'b0;
    chk("post_hs_valid", {63'h0, resp_valid}, 64'h0);
    chk("post_hs_req_ready", {63'h0, req_ready}, 64'h1);
  endtask

  task automatic model_txn(input logic wen, input logic [63:0] a, input logic [63:0] d,
                           input logic [7:0] m, input int hold);
    logic        e;
    logic [63:0] rd;
    e  = !in_range(a);
    rd = 64'h0;
    if (!wen && !e && mem_m.exists(word_idx(a))) rd = mem_m[word_idx(a)];
    txn(wen, a, d, m, hold, e, rd);
    model_apply(wen, a, d, m);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] oor [6];
    logic [63:0] a, d;
    logic        w;

    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    resp_ready = 1'b0;
    r1_req_valid = 1'b0; r1_req_wen = 1'b0; r1_req_addr = '0; r1_req_wdata = '0;
    r1_req_wmask = '0; r1_resp_ready = 1'b0;

    vecs[0] = '{1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, 64'h0};
    vecs[1] = '{1'b0, 64'h8000_0010, 64'h0, 8'h00, 1'b0, 64'h1122_3344_5566_7788};
    vecs[2] = '{1'b1, 64'h8000_0010, 64'h0000_0000_0000_00AB, 8'h01, 1'b0, 64'h0};
    vecs[3] = '{1'b0, 64'h8000_0010, 64'h0, 8'h00, 1'b0, 64'h1122_3344_5566_77AB};
    vecs[4] = '{1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 1'b1, 64'h0};
    vecs[5] = '{1'b0, 64'h8000_2000, 64'h0, 8'h00, 1'b1, 64'h0};
    vecs[6] = '{1'b0, 64'h8000_0010, 64'h0, 8'h00, 1'b0, 64'h1122_3344_5566_77AB};
    vecs[7] = '{1'b1, 64'h8000_0017, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b0, 64'h0};
    vecs[8] = '{1'b0, 64'h8000_0010, 64'h0, 8'h00, 1'b0, 64'h1122_3344_5566_77AB};

    repeat (3) next_cycle();
    chk("rst_req_ready", {63'h0, req_ready}, 64'h0);
    chk("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
    chk("rst_resp_err", {63'h0, resp_err}, 64'h0);
    chk("rst_resp_rdata", resp_rdata, 64'h0);
    chk("rst_r1_req_ready", {63'h0, r1_req_ready}, 64'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", {63'h0, req_ready}, 64'h1);

    foreach (vecs[i]) begin
      txn(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, 0,
          vecs[i].exp_err, vecs[i].exp_rdata);
      model_apply(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
    end

    // Backpressure: five stalled cycles, handshake on the sixth.
    txn(1'b0, 64'h8000_0010, 64'h0, 8'h00, 5, 1'b0, 64'h1122_3344_5566_77AB);

    // Reset while a store sits in WAIT: response dropped, write kept.
    req_wen = 1'b1; req_addr = 64'h8000_0020; req_wdata = 64'hCAFE; req_wmask = 8'hFF;
    req_valid = 1'b1;
    next_cycle();
    req_valid = 1'b0;
    chk("wait_no_resp", {63'h0, resp_valid}, 64'h0);
    rst = 1'b1;
    next_cycle();
    chk("rst_wait_valid", {63'h0, resp_valid}, 64'h0);
    chk("rst_wait_err", {63'h0, resp_err}, 64'h0);
    chk("rst_wait_req_ready", {63'h0, req_ready}, 64'h0);
    rst = 1'b0;
    #1;
    chk("rst_wait_idle", {63'h0, req_ready}, 64'h1);
    next_cycle();
    chk("rst_wait_quiet", {63'h0, resp_valid}, 64'h0);
    model_apply(1'b1, 64'h8000_0020, 64'hCAFE, 8'hFF);
    model_txn(1'b0, 64'h8000_0020, 64'h0, 8'h00, 0);

    // Reset while a load response is being presented.
    req_wen = 1'b0; req_addr = 64'h8000_0010; req_valid = 1'b1;
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    chk("resp_before_rst", {63'h0, resp_valid}, 64'h1);
    rst = 1'b1;
    next_cycle();
    chk("rst_resp_dropped", {63'h0, resp_valid}, 64'h0);
    chk("rst_resp_rdata0", resp_rdata, 64'h0);
    rst = 1'b0;
    #1;
    chk("rst_resp_idle", {63'h0, req_ready}, 64'h1);

    // Randomized traffic over a 16-word window plus out-of-range addresses.
    for (int i = 0; i < 16; i++)
      model_txn(1'b1, BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF, 0);
    oor[0] = 64'h7FFF_FFF8;
    oor[1] = 64'h7FFF_FFFF;
    oor[2] = 64'h0;
    oor[3] = 64'h8000_2000;
    oor[4] = 64'h8000_2018;
    oor[5] = 64'hFFFF_FFFF_FFFF_FFF8;
    for (int n = 0; n < 80; n++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) < 6)
        a = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
      else
        a = oor[$urandom_range(0, 5)];
      d = {$urandom, $urandom};
      model_txn(w, a, d, 8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 16; i++)
      model_txn(1'b0, BASE + 64'(8 * i), 64'h0, 8'h00, 0);

    // LATENCY=1 build: store, then back-to-back loads with resp_ready held high.
    r1_resp_ready = 1'b1;
    r1_req_wen = 1'b1; r1_req_addr = BASE + 64'h8;
    r1_req_wdata = 64'h0123_4567_89AB_CDEF; r1_req_wmask = 8'hFF;
    r1_req_valid = 1'b1;
    chk("l1_ready_start", {63'h0, r1_req_ready}, 64'h1);
    next_cycle();
    r1_req_wen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      chk("l1_resp_valid", {63'h0, r1_resp_valid}, {63'h0, 1'(i % 2)});
      chk("l1_req_ready", {63'h0, r1_req_ready}, {63'h0, 1'((i + 1) % 2)});
      if (i >= 3 && (i % 2) == 1)
        chk("l1_rdata", r1_resp_rdata, 64'h0123_4567_89AB_CDEF);
      next_cycle();
    end
    r1_req_valid = 1'b0;
    r1_resp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the load/store interface driven by the memory stage.
- Accepts one request at a time over a valid/ready handshake, into an internal byte-maskable 64-bit word RAM.
- Returns read data or an error after a fixed, programmable latency, with a response handshake.
- Replaces combinational DPI memory access in simulation with a cycle-accurate, synthesizable model.

Parameters:
- XLEN, 64, data/address width in bits.
- DEPTH_WORDS, 1024, number of 64-bit words in the array (power of two).
- BASE_ADDR, 64'h8000_0000, byte address of word 0 (equals PC_RESET_ADDR).
- LATENCY, 2, cycles from request acceptance to response valid (legal range 1..15).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_wen  input  1  1 = store, 0 = load
- req_addr  input  XLEN  byte address; bits [2:0] ignored (aligned-word access)
- req_wdata  input  XLEN  store data, already lane-aligned by the requester
- req_wmask  input  8  byte-enable per lane, bit i -> wdata[8i+7:8i]
- resp_valid  output  1  response present
- resp_ready  input  1  requester consumes response
- resp_rdata  output  XLEN  full 64-bit word read (0 for stores and errors)
- resp_err  output  1  address out of range

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst; reset is sampled only at the clk rising edge.
- FSM states: IDLE, WAIT, RESP. Reset -> IDLE.
- Reset values: resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. req_ready=0 while rst=1.
- RAM contents are not reset and keep their values across reset.
- req_ready=1 iff state==IDLE and rst=0. It is a combinational decode of registered state only and never depends on req_valid.
- Acceptance: req_valid && req_ready at edge T.
  - Latches the error flag and the read word.
  - For stores, writes masked lanes at edge T.
- Range check: idx=(req_addr-BASE_ADDR)>>3. Error if req_addr<BASE_ADDR or idx>=DEPTH_WORDS.
  - An errored store writes nothing.
  - An errored load returns rdata=0.
- Read data is the word contents before any same-edge write. Only one request is outstanding, so a store's data is never needed by its own response.
- Store with wmask=0: no RAM change, normal response with err=0 and rdata=0.
- Latency handling:
  - LATENCY==1: IDLE -> RESP directly, so resp_valid=1 in cycle T+1.
  - LATENCY>1: IDLE -> WAIT with counter=LATENCY-1, decrement each cycle, WAIT -> RESP when counter reaches 1. resp_valid is first high in cycle T+LATENCY.
- RESP: resp_valid=1 and resp_rdata/resp_err held stable until resp_valid && resp_ready at an edge, then -> IDLE.
  - The next request can be accepted the cycle after the handshake (no same-cycle turnaround).
- Backpressure: resp_ready=0 holds RESP indefinitely, with req_ready=0 throughout.
- Reset mid-operation (WAIT or RESP): pending response is dropped, -> IDLE, outputs return to reset values. A store already accepted remains committed.
- Address arithmetic is XLEN-bit unsigned, so wrap-around below BASE_ADDR counts as out of range.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum (IDLE/WAIT/RESP);
  - XLEN;
  - default BASE_ADDR tied to PC_RESET_ADDR;
  - the mask width constant 8.
- Sub-module dmem_array: single-port synchronous RAM, DEPTH_WORDS x 64, 8 byte-write enables, read-before-write on the same edge. Instantiated once.
- FSM, counter and range check stay in dmem_responder.

Test Plan:
- Reset then store addr=0x8000_0010, wdata=0x1122334455667788, wmask=0xFF; then load the same addr.
  - Store response resp_valid at T+2, err=0.
  - Load returns 0x1122334455667788.
- Byte store addr=0x8000_0010, wdata=0x00000000000000AB, wmask=0x01, then load.
  - Returns 0x11223344556677AB.
  - Lanes 1..7 unchanged.
- Load addr=0x7FFF_FFF8 and load addr=BASE+8*DEPTH_WORDS.
  - Both return resp_err=1, rdata=0.
  - A subsequent in-range load shows RAM untouched.
- Hold resp_ready=0 for 5 cycles after resp_valid.
  - resp_valid/rdata/err stable, req_ready=0 throughout.
  - Handshake on cycle 6, then req_ready=1 the next cycle.
- Assert rst during WAIT of a store to 0x8000_0020 (wdata=0xCAFE, wmask=0xFF).
  - Next cycle resp_valid=0 and state IDLE.
  - A later load of 0x8000_0020 returns 0xCAFE.
- LATENCY=1 build, back-to-back loads with resp_ready tied 1.
  - One accept every 2 cycles.
  - resp_valid exactly one cycle after each accept.
